eeprom_seq: RTL and testbench
=============================

Name: eeprom_seq

Overview:
- Command sequencer that sits directly upstream of the EEPROM serial read/write controller.
- On START it drives the controller's parallel interface (WR, RD, ADDR, DATA) and consumes its one-cycle ACK.
- It writes a block of NUM_BYTES pattern bytes to consecutive EEPROM addresses, then reads the same addresses back and compares them.
- It reports completion, mismatches and ACK timeouts to the system-level test logic.

Parameters:
- BASE_ADDR, 11'h000, first EEPROM byte address of the block.
- NUM_BYTES, 8, bytes per block (1..256).
- SEED, 8'hA5, expected byte i = (SEED + i) mod 256.
- WAIT_CYC, 16, idle CLK cycles after each write ACK (EEPROM internal write time).
- TIMEOUT, 1023, maximum CLK cycles to wait for ACK per transaction.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  begin one write+verify pass; sampled only in IDLE.
- BUSY  output  1  high from the cycle after START until FINISH.
- DONE  output  1  one-cycle pulse at end of pass.
- ERR  output  1  high if any mismatch or timeout in the last pass; cleared on next accepted START.
- TMO  output  1  high if the last pass aborted on ACK timeout; cleared on next accepted START.
- ERR_CNT  output  8  mismatch count of the last pass, saturates at 255; cleared on START.
- WR  output  1  one-cycle write request to controller.
- RD  output  1  one-cycle read request to controller.
- ADDR  output  11  EEPROM byte address; held stable for the whole transaction.
- DATA  inout  8  driven with the write byte from W_REQ through W_WAIT, otherwise 8'hzz; sampled during read.
- ACK  input  1  one-cycle completion pulse from controller.

Behaviour:
- Reset (RESET=0, async): state=IDLE; BUSY, DONE, ERR, TMO, WR, RD = 0; ERR_CNT=0; ADDR=BASE_ADDR; DATA=8'hzz; idx=0; counters=0. Takes effect immediately mid-transaction.
- State IDLE: on START=1, clear ERR/TMO/ERR_CNT, idx=0, go W_REQ. START in any other state is ignored.
- W_REQ (1 cycle):
  - WR=1, ADDR=BASE_ADDR+idx (11-bit wrap), DATA driven with SEED+idx.
  - Go W_WAIT, WR=0 on the next cycle.
- W_WAIT:
  - DATA stays driven; tcnt counts up from 0.
  - ACK=1 -> release DATA, load gap counter with WAIT_CYC, go W_GAP.
  - tcnt reaching TIMEOUT without ACK -> TMO=1, ERR=1, go FINISH.
- W_GAP:
  - Count down; at 0: if idx==NUM_BYTES-1 then idx=0 and go R_REQ, else idx+1 and go W_REQ.
  - With WAIT_CYC=0, W_GAP lasts exactly 1 cycle.
- R_REQ (1 cycle): RD=1, ADDR=BASE_ADDR+idx, DATA hi-Z; go R_WAIT.
- R_WAIT:
  - ACK=1 -> capture DATA into rd_byte, go R_CMP.
  - Timeout behaves as in W_WAIT.
- R_CMP (1 cycle):
  - If rd_byte != SEED+idx: ERR=1 and ERR_CNT+1 (holds at 255).
  - Then idx==NUM_BYTES-1 -> FINISH, else idx+1 -> R_REQ.
- FINISH (1 cycle): DONE=1, BUSY=0 in the same cycle; go IDLE.
- ACK outside W_WAIT/R_WAIT is ignored.
- ACK in the same cycle that tcnt reaches TIMEOUT counts as success, not timeout.
- WR and RD are never both high. Neither is asserted within 2 cycles of the previous ACK, so the controller's Ackn->Idle return is respected.
- Request-to-ACK latency is set by the controller; this block adds 2 cycles of overhead per byte plus WAIT_CYC per write.

Test Plan:
1. Reset mid-W_WAIT with DATA driven -> WR=RD=0, DATA=8'hzz, BUSY=0 immediately; no DONE pulse follows.
2. NUM_BYTES=4, BASE_ADDR=11'h7FE, controller model returns the written bytes -> ADDR sequence 7FE,7FF,000,001 for both writes and reads. Write data A5,A6,A7,A8. DONE pulse; ERR=0, ERR_CNT=0.
3. Same setup, but the model corrupts the read at address 000 to 8'h00 -> ERR=1, ERR_CNT=1, TMO=0.
4. Model never ACKs the first write, TIMEOUT=20 -> DONE pulses 21 cycles after WR; TMO=1, ERR=1; no RD is ever issued.
5. START held high for 200 cycles during a pass, plus a spurious ACK during W_GAP -> exactly one pass; byte count and ADDR sequence are unchanged.
6. WAIT_CYC=0, NUM_BYTES=1 -> WR pulse, W_GAP lasts 1 cycle, then an RD pulse; DONE 1 cycle after R_CMP.

Source files
------------

// File: rtl/eeprom_seq.sv
// eeprom_seq: write/read-verify command sequencer for the EEPROM serial controller.
// Writes a seeded byte pattern to a block of addresses, reads it back and counts mismatches.
module eeprom_seq #(
    parameter logic [10:0] BASE_ADDR = 11'h000,
    parameter int          NUM_BYTES = 8,
    parameter logic [7:0]  SEED      = 8'hA5,
    parameter int          WAIT_CYC  = 16,
    parameter int          TIMEOUT   = 1023
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic        TMO,
    output logic [7:0]  ERR_CNT,
    output logic        WR,
    output logic        RD,
    output logic [10:0] ADDR,
    inout  wire  [7:0]  DATA,
    input  logic        ACK
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
    localparam logic [7:0] LAST = 8'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_REQ,
        S_W_WAIT,
        S_W_GAP,
        S_R_REQ,
        S_R_WAIT,
        S_R_CMP,
        S_FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    idx_q, idx_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [7:0]    rd_byte_q, rd_byte_d;
    logic          err_q, err_d;
    logic          tmo_q, tmo_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic [TW-1:0] tcnt_nx;
    logic [7:0]    exp_byte;
    logic          is_last;
    logic          data_oe;

    assign tcnt_nx  = tcnt_q + TW'(1);
    assign exp_byte = SEED + idx_q;
    assign is_last  = (idx_q == LAST);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            idx_q     <= 8'd0;
            tcnt_q    <= '0;
            gcnt_q    <= '0;
            rd_byte_q <= 8'd0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tcnt_q    <= tcnt_d;
            gcnt_q    <= gcnt_d;
            rd_byte_q <= rd_byte_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tcnt_d    = tcnt_q;
        gcnt_d    = gcnt_q;
        rd_byte_d = rd_byte_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        err_cnt_d = err_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    err_d     = 1'b0;
                    tmo_d     = 1'b0;
                    err_cnt_d = 8'd0;
                    idx_d     = 8'd0;
                    state_d   = S_W_REQ;
                end
            end
            S_W_REQ: begin
                tcnt_d  = '0;
                state_d = S_W_WAIT;
            end
            S_W_WAIT: begin
                // ACK wins over a timeout landing in the same cycle
                if (ACK) begin
                    gcnt_d  = GW'(WAIT_CYC);
                    state_d = S_W_GAP;
                end else if (tcnt_nx == TW'(TIMEOUT)) begin
                    tmo_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    tcnt_d = tcnt_nx;
                end
            end
            S_W_GAP: begin
                if (gcnt_q == '0) begin
                    if (is_last) begin
                        idx_d   = 8'd0;
                        state_d = S_R_REQ;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = S_W_REQ;
                    end
                end else begin
                    gcnt_d = gcnt_q - GW'(1);
                end
            end
            S_R_REQ: begin
                tcnt_d  = '0;
                state_d = S_R_WAIT;
            end
            S_R_WAIT: begin
                if (ACK) begin
                    rd_byte_d = DATA;
                    state_d   = S_R_CMP;
                end else if (tcnt_nx == TW'(TIMEOUT)) begin
                    tmo_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    tcnt_d = tcnt_nx;
                end
            end
            S_R_CMP: begin
                if (rd_byte_q != exp_byte) begin
                    err_d = 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
                if (is_last) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_R_REQ;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Requests and status decode straight from the state register
    assign BUSY    = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign DONE    = (state_q == S_FINISH);
    assign WR      = (state_q == S_W_REQ);
    assign RD      = (state_q == S_R_REQ);
    assign ERR     = err_q;
    assign TMO     = tmo_q;
    assign ERR_CNT = err_cnt_q;
    assign ADDR    = BASE_ADDR + {3'b000, idx_q};

    assign data_oe = (state_q == S_W_REQ) || (state_q == S_W_WAIT);
    assign DATA    = data_oe ? exp_byte : 8'hzz;

endmodule

// File: tb/tb_eeprom_seq.sv
// Directed bench for eeprom_seq: a 4-byte block wrapping the top of the
// address space, and a single-byte block with no write gap.
module tb_eeprom_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    logic        start_a;
    logic        busy_a, done_a, err_a, tmo_a, wr_a, rd_a;
    logic [7:0]  ecnt_a;
    logic [10:0] addr_a;
    wire  [7:0]  data_a;
    logic        ack_a, spur_a;
    logic        md_en_a;
    logic [7:0]  md_val_a;
    logic        pr_en;
    logic [7:0]  pr_val;
    logic        ack_on_a, bad0_a;

    logic        start_b;
    logic        busy_b, done_b, err_b, tmo_b, wr_b, rd_b;
    logic [7:0]  ecnt_b;
    logic [10:0] addr_b;
    wire  [7:0]  data_b;
    logic        ack_b;
    logic        md_en_b;
    logic [7:0]  md_val_b;

    assign data_a = md_en_a ? md_val_a : (pr_en ? pr_val : 8'hzz);
    assign data_b = md_en_b ? md_val_b : 8'hzz;

    eeprom_seq #(
        .BASE_ADDR(11'h7FE), .NUM_BYTES(4), .SEED(8'hA5),
        .WAIT_CYC(50), .TIMEOUT(20)
    ) u_a (
        .CLK(clk), .RESET(rst_n), .START(start_a), .BUSY(busy_a),
        .DONE(done_a), .ERR(err_a), .TMO(tmo_a), .ERR_CNT(ecnt_a),
        .WR(wr_a), .RD(rd_a), .ADDR(addr_a), .DATA(data_a),
        .ACK(ack_a | spur_a)
    );

    eeprom_seq #(
        .BASE_ADDR(11'h000), .NUM_BYTES(1), .SEED(8'hA5),
        .WAIT_CYC(0), .TIMEOUT(20)
    ) u_b (
        .CLK(clk), .RESET(rst_n), .START(start_b), .BUSY(busy_b),
        .DONE(done_b), .ERR(err_b), .TMO(tmo_b), .ERR_CNT(ecnt_b),
        .WR(wr_b), .RD(rd_b), .ADDR(addr_b), .DATA(data_b),
        .ACK(ack_b)
    );

    // Controller models: ACK three cycles after a request, read data with it
    logic [7:0]  mem_a [2048];
    logic [10:0] wa_q [$];
    logic [7:0]  wd_q [$];
    logic [10:0] ra_q [$];
    int          cnt_a = 0;
    logic        rdp_a = 1'b0;
    logic [10:0] rad_a = 11'd0;
    int          wrrd = 0;

    initial begin
        ack_a = 1'b0;
        md_en_a = 1'b0;
        md_val_a = 8'h00;
        forever begin
            @(negedge clk);
            ack_a = 1'b0;
            md_en_a = 1'b0;
            if (cnt_a > 0) begin
                cnt_a = cnt_a - 1;
                if (cnt_a == 0) begin
                    ack_a = 1'b1;
                    if (rdp_a) begin
                        md_en_a = 1'b1;
                        md_val_a = (bad0_a && rad_a == 11'h000) ? 8'h00 : mem_a[rad_a];
                    end
                end
            end
            if (wr_a && rd_a) wrrd = wrrd + 1;
            if (wr_a) begin
                wa_q.push_back(addr_a);
                wd_q.push_back(data_a);
                mem_a[addr_a] = data_a;
                if (ack_on_a) begin
                    cnt_a = 3;
                    rdp_a = 1'b0;
                end
            end
            if (rd_a) begin
                ra_q.push_back(addr_a);
                if (ack_on_a) begin
                    cnt_a = 3;
                    rdp_a = 1'b1;
                    rad_a = addr_a;
                end
            end
        end
    end

    logic [7:0]  mem_b [2048];
    logic [10:0] wb_q [$];
    logic [7:0]  wbd_q [$];
    logic [10:0] rb_q [$];
    int          cnt_b = 0;
    logic        rdp_b = 1'b0;
    logic [10:0] rad_b = 11'd0;

    initial begin
        ack_b = 1'b0;
        md_en_b = 1'b0;
        md_val_b = 8'h00;
        forever begin
            @(negedge clk);
            ack_b = 1'b0;
            md_en_b = 1'b0;
            if (cnt_b > 0) begin
                cnt_b = cnt_b - 1;
                if (cnt_b == 0) begin
                    ack_b = 1'b1;
                    if (rdp_b) begin
                        md_en_b = 1'b1;
                        md_val_b = mem_b[rad_b];
                    end
                end
            end
            if (wr_b && rd_b) wrrd = wrrd + 1;
            if (wr_b) begin
                wb_q.push_back(addr_b);
                wbd_q.push_back(data_b);
                mem_b[addr_b] = data_b;
                cnt_b = 3;
                rdp_b = 1'b0;
            end
            if (rd_b) begin
                rb_q.push_back(addr_b);
                cnt_b = 3;
                rdp_b = 1'b1;
                rad_b = addr_b;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pass on u_a; cycle 0 is the W_REQ cycle, -1 means never seen
    task automatic run_a(output int done_at, output int wr_at);
        done_at = -1;
        wr_at = -1;
        start_a = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (wr_a && wr_at < 0) wr_at = i;
            if (done_a) begin
                done_at = i;
                break;
            end
        end
    endtask

    logic [10:0] exp_addr [4] = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
    logic [7:0]  exp_data [4] = '{8'hA5, 8'hA6, 8'hA7, 8'hA8};

    initial begin
        int dn, wt, rt, bw, br, nd, nb;
        start_a = 1'b0;
        start_b = 1'b0;
        spur_a = 1'b0;
        pr_en = 1'b0;
        pr_val = 8'h00;
        ack_on_a = 1'b1;
        bad0_a = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_tmo", tmo_a, 0);
        chk("rst_ecnt", ecnt_a, 0);
        chk("rst_wr_rd", {wr_a, rd_a, wr_b, rd_b}, 0);
        chk("rst_addr_a", addr_a, 11'h7FE);
        chk("rst_addr_b", addr_b, 11'h000);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of W_WAIT
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("t1_wr", wr_a, 1);
        chk("t1_wdata", data_a, 8'hA5);
        chk("t1_busy", busy_a, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_busy_rst", busy_a, 0);
        chk("t1_wr_rd_rst", {wr_a, rd_a}, 0);
        pr_val = 8'h3C;
        pr_en = 1'b1;
        #1;
        chk("t1_data_released", data_a, 8'h3C);
        pr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        nb = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done_a) nd++;
            if (busy_a) nb++;
        end
        chk("t1_no_done", nd, 0);
        chk("t1_no_busy", nb, 0);

        // Clean pass across the address wrap
        bw = wa_q.size();
        br = ra_q.size();
        run_a(dn, wt);
        chk("t2_done_cycle", dn, 240);
        chk("t2_wr_first", wt, 0);
        chk("t2_err", err_a, 0);
        chk("t2_ecnt", ecnt_a, 0);
        chk("t2_tmo", tmo_a, 0);
        chk("t2_busy_at_done", busy_a, 0);
        chk("t2_nwr", wa_q.size() - bw, 4);
        chk("t2_nrd", ra_q.size() - br, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_waddr%0d", k), wa_q[bw + k], exp_addr[k]);
            chk($sformatf("t2_wdata%0d", k), wd_q[bw + k], exp_data[k]);
            chk($sformatf("t2_raddr%0d", k), ra_q[br + k], exp_addr[k]);
        end
        @(negedge clk);
        chk("t2_done_pulse", done_a, 0);

        // Corrupted read at address 000
        bad0_a = 1'b1;
        run_a(dn, wt);
        bad0_a = 1'b0;
        chk("t3_done_cycle", dn, 240);
        chk("t3_err", err_a, 1);
        chk("t3_ecnt", ecnt_a, 1);
        chk("t3_tmo", tmo_a, 0);
        @(negedge clk);

        // Write never acknowledged
        ack_on_a = 1'b0;
        br = ra_q.size();
        run_a(dn, wt);
        chk("t4_done_seen", dn >= 0, 1);
        chk("t4_done_after_wr", dn - wt, 21);
        chk("t4_tmo", tmo_a, 1);
        chk("t4_err", err_a, 1);
        chk("t4_ecnt", ecnt_a, 0);
        repeat (10) @(negedge clk);
        chk("t4_no_rd", ra_q.size() - br, 0);
        ack_on_a = 1'b1;

        // START held for 200 cycles, spurious ACK inside the first write gap
        bw = wa_q.size();
        br = ra_q.size();
        nd = 0;
        dn = -1;
        start_a = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i == 199) start_a = 1'b0;
            spur_a = (i == 20);
            if (done_a) begin
                nd++;
                dn = i;
            end
        end
        chk("t5_one_pass", nd, 1);
        chk("t5_done_cycle", dn, 240);
        chk("t5_busy_end", busy_a, 0);
        chk("t5_err", err_a, 0);
        chk("t5_tmo", tmo_a, 0);
        chk("t5_nwr", wa_q.size() - bw, 4);
        chk("t5_nrd", ra_q.size() - br, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t5_waddr%0d", k), wa_q[bw + k], exp_addr[k]);
            chk($sformatf("t5_raddr%0d", k), ra_q[br + k], exp_addr[k]);
        end

        // Single byte, no write gap
        wt = -1;
        rt = -1;
        dn = -1;
        start_b = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (wr_b && wt < 0) wt = i;
            if (rd_b && rt < 0) rt = i;
            if (done_b && dn < 0) begin
                dn = i;
                chk("t6_busy_at_done", busy_b, 0);
                chk("t6_err", err_b, 0);
                chk("t6_tmo", tmo_b, 0);
                chk("t6_ecnt", ecnt_b, 0);
            end
        end
        chk("t6_wr_cycle", wt, 0);
        chk("t6_rd_cycle", rt, 5);
        chk("t6_done_cycle", dn, 10);
        chk("t6_nwr", wb_q.size(), 1);
        chk("t6_nrd", rb_q.size(), 1);
        chk("t6_waddr", wb_q[0], 11'h000);
        chk("t6_wdata", wbd_q[0], 8'hA5);
        chk("t6_raddr", rb_q[0], 11'h000);

        chk("wr_rd_exclusive", wrrd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
